// File: rtl/addr_bus_arbiter.sv
// Round-robin arbiter for the shared 16-bit address bus.
// It picks one of seven address sources, drives the bus source selector, and
// returns a one-hot grant. A requester that asserts lock can keep the bus,
// but a hold-time watchdog takes the bus back if the requester holds it too long.
module addr_bus_arbiter #(
    parameter int N_REQ          = 7,
    parameter int SELECTOR_WIDTH = 4,
    parameter int MAX_HOLD       = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,      // active-high asynchronous reset
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          lock,
    output logic [N_REQ-1:0]          gnt,
    output logic [SELECTOR_WIDTH-1:0] in_selector,
    output logic                      bus_busy,
    output logic                      timeout_err
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PTR_W:0]   N_REQ_W   = (PTR_W + 1)'(N_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(N_REQ - 1);
    localparam logic [7:0]       HOLD_LAST = 8'(MAX_HOLD - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t                    state_reg;
    logic [PTR_W-1:0]          rr_ptr_reg;
    logic [PTR_W-1:0]          owner_reg;
    logic [7:0]                hold_cnt_reg;
    logic [N_REQ-1:0]          gnt_reg;
    logic [SELECTOR_WIDTH-1:0] sel_reg;
    logic                      timeout_reg;

    // Requests rotated so that offset 0 corresponds to the round-robin pointer.
    logic [PTR_W-1:0] cand_idx [N_REQ];
    logic [N_REQ-1:0] rot_req;

    logic             win_found;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W-1:0] next_ptr;
    logic             owner_locked;
    logic             keep_owner;
    logic             timed_out;

    // Map a requester index to its bus source code. Unknown indices park the bus on source 0.
    function automatic logic [SELECTOR_WIDTH-1:0] sel_code(input logic [PTR_W-1:0] idx);
        case (idx)
            PTR_W'(0): sel_code = SELECTOR_WIDTH'(1);   // pc
            PTR_W'(1): sel_code = SELECTOR_WIDTH'(2);   // sp
            PTR_W'(2): sel_code = SELECTOR_WIDTH'(7);   // mem
            PTR_W'(3): sel_code = SELECTOR_WIDTH'(8);   // imm
            PTR_W'(4): sel_code = SELECTOR_WIDTH'(9);   // fetch
            PTR_W'(5): sel_code = SELECTOR_WIDTH'(10);  // decode
            PTR_W'(6): sel_code = SELECTOR_WIDTH'(11);  // alu
            default:   sel_code = '0;
        endcase
    endfunction

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rotate
            logic [PTR_W:0] idx_sum;
            assign idx_sum = {1'b0, rr_ptr_reg} + (PTR_W + 1)'(gi);
            // Wrap the sum back into the range 0..N_REQ-1. The sum never reaches 2*N_REQ.
            assign cand_idx[gi] = (idx_sum >= N_REQ_W) ? PTR_W'(idx_sum - N_REQ_W)
                                                       : PTR_W'(idx_sum);
            assign rot_req[gi]  = req[cand_idx[gi]];
        end
    endgenerate

    // Select the first requester at or after the pointer. The downward scan lets the lowest offset win.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                win_found = 1'b1;
                win_idx   = cand_idx[i];
            end
        end
    end

    // Compute the next pointer position and decide whether the current owner keeps the bus.
    always_comb begin
        next_ptr     = (win_idx == LAST_IDX) ? '0 : win_idx + PTR_W'(1);
        owner_locked = req[owner_reg] && lock[owner_reg];
        keep_owner   = owner_locked && (hold_cnt_reg < HOLD_LAST);
        timed_out    = owner_locked && (hold_cnt_reg >= HOLD_LAST);
    end

    // Arbitration FSM: track the owner and the hold count, and register all outputs.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= '0;
            owner_reg    <= '0;
            hold_cnt_reg <= '0;
            gnt_reg      <= '0;
            sel_reg      <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            // The watchdog pulse lines up with the first cycle after the forced release.
            timeout_reg <= (state_reg == OWN) && timed_out;
            if (state_reg == OWN && keep_owner) begin
                hold_cnt_reg <= hold_cnt_reg + 8'd1;
            end else if (win_found) begin
                state_reg    <= OWN;
                owner_reg    <= win_idx;
                rr_ptr_reg   <= next_ptr;
                hold_cnt_reg <= '0;
                gnt_reg      <= N_REQ'(1) << win_idx;
                sel_reg      <= sel_code(win_idx);
            end else begin
                state_reg    <= IDLE;
                hold_cnt_reg <= '0;
                gnt_reg      <= '0;
                sel_reg      <= '0;
            end
        end
    end

    assign gnt         = gnt_reg;
    assign in_selector = sel_reg;
    assign bus_busy    = |gnt_reg;
    assign timeout_err = timeout_reg;

    // Structural invariants on the grant outputs.
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (reset_n) $onehot0(gnt));
    a_sel_idle:    assert property (@(posedge clk) disable iff (reset_n)
                                    ((in_selector == '0) == (gnt == '0)));
    a_busy:        assert property (@(posedge clk) disable iff (reset_n) (bus_busy == |gnt));

endmodule

// File: tb/tb_addr_bus_arbiter.sv
// Directed testbench for addr_bus_arbiter. Every expected value below is a
// constant worked out by hand from the arbitration rules.
module tb_addr_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] req;
    logic [6:0] lock;
    logic [6:0] gnt;
    logic [3:0] in_selector;
    logic       bus_busy;
    logic       timeout_err;

    int checks_total  = 0;
    int checks_passed = 0;

    addr_bus_arbiter #(
        .N_REQ(7),
        .SELECTOR_WIDTH(4),
        .MAX_HOLD(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req(req),
        .lock(lock),
        .gnt(gnt),
        .in_selector(in_selector),
        .bus_busy(bus_busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got !== exp)
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        else
            checks_passed++;
    endtask

    task automatic expect_out(input string tag, input logic [6:0] exp_gnt,
                              input logic [3:0] exp_sel, input logic exp_to);
        $display("[%0t] %s req=%b lock=%b gnt=%b sel=%0d busy=%b to=%b",
                 $time, tag, req, lock, gnt, in_selector, bus_busy, timeout_err);
        check({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
        check({tag, ".sel"}, 32'(in_selector), 32'(exp_sel));
        check({tag, ".busy"}, 32'(bus_busy), 32'(|exp_gnt));
        check({tag, ".to"}, 32'(timeout_err), 32'(exp_to));
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] rot_gnt [6];
        logic [3:0] rot_sel [6];
        rot_gnt = '{7'b0000010, 7'b0000100, 7'b0001000, 7'b0010000, 7'b0100000, 7'b1000000};
        rot_sel = '{4'd2, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11};

        reset_n = 1'b1;
        req     = '0;
        lock    = '0;
        step;
        expect_out("reset", 7'b0, 4'd0, 1'b0);
        #2 reset_n = 1'b0;

        // 1: pc alone, then drop the request
        req = 7'b0000001;
        step;
        expect_out("t1_pc", 7'b0000001, 4'd1, 1'b0);
        req = 7'b0;
        step;
        expect_out("t1_idle", 7'b0, 4'd0, 1'b0);

        // 2: all requesting, no lock. The pointer is at sp after the pc grant.
        req = 7'b1111111;
        for (int k = 0; k < 6; k++) begin
            step;
            expect_out($sformatf("t2_rot%0d", k), rot_gnt[k], rot_sel[k], 1'b0);
        end

        // 3: alu won last, so pc and alu alternate
        req = 7'b1000001;
        step; expect_out("t3_pc0", 7'b0000001, 4'd1, 1'b0);
        step; expect_out("t3_alu0", 7'b1000000, 4'd11, 1'b0);
        step; expect_out("t3_pc1", 7'b0000001, 4'd1, 1'b0);
        step; expect_out("t3_alu1", 7'b1000000, 4'd11, 1'b0);
        req = 7'b0;
        step; expect_out("t3_idle", 7'b0, 4'd0, 1'b0);

        // lock without req is ignored
        lock = 7'b1111111;
        step; expect_out("lock_noreq", 7'b0, 4'd0, 1'b0);

        // 4: fetch locked hits the watchdog while decode waits
        req  = 7'b0110000;
        lock = 7'b0010000;
        for (int k = 0; k < 8; k++) begin
            step;
            expect_out($sformatf("t4_fetch%0d", k), 7'b0010000, 4'd9, 1'b0);
        end
        step; expect_out("t4_decode", 7'b0100000, 4'd10, 1'b1);
        step; expect_out("t4_refetch", 7'b0010000, 4'd9, 1'b0);
        req  = 7'b0;
        lock = 7'b0;
        step; expect_out("t4_idle", 7'b0, 4'd0, 1'b0);

        // 5: sp locked for 3 cycles, then it drops req and mem takes over
        req  = 7'b0000110;
        lock = 7'b0000010;
        step; expect_out("t5_sp0", 7'b0000010, 4'd2, 1'b0);
        step; expect_out("t5_sp1", 7'b0000010, 4'd2, 1'b0);
        step; expect_out("t5_sp2", 7'b0000010, 4'd2, 1'b0);
        req = 7'b0000100;
        step; expect_out("t5_mem", 7'b0000100, 4'd7, 1'b0);
        step; expect_out("t5_mem_b2b", 7'b0000100, 4'd7, 1'b0);
        req  = 7'b0;
        lock = 7'b0;
        step; expect_out("t5_idle", 7'b0, 4'd0, 1'b0);

        // 6: asynchronous reset during a locked imm grant
        req  = 7'b0001000;
        lock = 7'b0001000;
        step; expect_out("t6_imm", 7'b0001000, 4'd8, 1'b0);
        #2 reset_n = 1'b1;
        #1 expect_out("t6_async_rst", 7'b0, 4'd0, 1'b0);
        #1 reset_n = 1'b0;
        lock = 7'b0;
        step; expect_out("t6_imm_again", 7'b0001000, 4'd8, 1'b0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
